bfly_addsub_sched: RTL and testbench
====================================

Name: bfly_addsub_sched

Overview:
Scheduler that time-shares one complex half-precision add/sub unit to produce radix-2 butterfly pairs (A+B, A-B). It accepts one operand pair per transaction and issues two operations to the shared unit: ADD first, then SUB. It collects the two in-order results and presents them as one paired output. It sits between the butterfly operand buffer and the complex add/sub datapath and limits the number of in-flight pairs with a credit counter.

Parameters:
WIDTH, 16, width of each real/imag component (half-precision FP bit pattern, passed through opaque)
MAX_PAIRS, 4, maximum accepted-but-not-delivered butterfly pairs (1..15)
CNT_W, 4, credit counter width; must hold MAX_PAIRS

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_vld  input  1  operand pair valid
in_rdy  output  1  operand pair accepted when in_vld & in_rdy
in_a_real, in_a_img, in_b_real, in_b_img  input  WIDTH each  operands A and B
op_vld  output  1  issue valid to add/sub unit (drives A_vld and B_vld)
op_rdy  input  1  unit ready (A_rdy & B_rdy, combined externally)
op_is_sub  output  1  0 = A+B, 1 = A-B
op_a_real, op_a_img, op_b_real, op_b_img  output  WIDTH each  operands to unit
res_vld  input  1  unit result valid
res_rdy  output  1  result accept (drives unit S_rdy)
res_real, res_img  input  WIDTH each  unit result
out_vld  output  1  butterfly pair valid
out_rdy  input  1  downstream accept
out_sum_real, out_sum_img, out_dif_real, out_dif_img  output  WIDTH each  A+B and A-B
inflight  output  CNT_W  current credit count (pairs outstanding)
err  output  1  sticky protocol error

Behaviour:
- Reset (rst_n low, asynchronous): issue FSM and collect FSM go to their first states (ISS_IDLE, COL_SUM); inflight=0; err=0; all operand, sum and diff registers are 0. Therefore in_rdy=1, op_vld=0, op_is_sub=0, res_rdy=1, out_vld=0. Reset mid-operation discards all state; results still in the unit after reset are not tracked.
- Issue FSM:
  - ISS_IDLE: in_rdy = (inflight < MAX_PAIRS). On accept, register A and B, go to ISS_ADD.
  - ISS_ADD: op_vld=1, op_is_sub=0. On op_rdy, go to ISS_SUB.
  - ISS_SUB: op_vld=1, op_is_sub=1, same operands. On op_rdy, go to ISS_IDLE.
  - Operands are held stable while op_vld=1 and op_rdy=0.
  - Peak throughput is one pair per 3 cycles. in_rdy is combinational from state and counter only, never from in_vld.
- Credit counter:
  - +1 on input accept; -1 on output handshake (out_vld & out_rdy).
  - Both in the same cycle leave it unchanged.
  - Accept is never allowed at inflight==MAX_PAIRS.
- Collect FSM (results return in issue order, alternating sum/diff):
  - COL_SUM: res_rdy=1. On res_vld, capture the result into the sum registers and go to COL_DIF.
  - COL_DIF: res_rdy=1. On res_vld, capture the result into the diff registers and go to COL_OUT.
  - COL_OUT: res_rdy=0, out_vld=1. Outputs are held stable until out_rdy. On handshake, go to COL_SUM.
  - Output latency from the second result handshake to out_vld is 1 cycle.
- err:
  - Set when res_vld=1 in COL_SUM while inflight==0 (result with no outstanding pair).
  - Set when an output handshake would underflow the counter.
  - Sticky until reset. The counter saturates at 0 and never wraps.
- Issue and collect sides run independently: ISS_ADD of pair n+1 may overlap COL_OUT of pair n, subject to credits.

Test Plan:
- Single pair: A=0x3C00+j0x4000 (1+2j), B=0x3800+j0x3800 (0.5+0.5j); bench unit model has 4-cycle latency. Required: op_is_sub sequence 0 then 1; out_sum=0x3E00/0x4100, out_dif=0x3800/0x3E00; inflight back to 0 after the out handshake.
- Credit limit: MAX_PAIRS=4, out_rdy=0, in_vld held high. Required: exactly 4 accepts, then in_rdy=0 with inflight=4. Raise out_rdy for 1 cycle: exactly one further accept, in the cycle after the handshake or later.
- Unit backpressure: op_rdy low for 5 cycles during ISS_ADD. Required: op_vld, op_is_sub=0 and operands stable; no accept; SUB issued only after ADD completes.
- Output stall: out_rdy=0 for 10 cycles with a pair in COL_OUT. Required: res_rdy=0; res_vld held by the model; output data unchanged; after out_rdy, next pair delivered correctly and in order.
- Simultaneous accept and deliver at inflight=2. Required: inflight stays 2.
- Async reset asserted mid-ISS_SUB with 2 pairs in flight. Required: immediately in_rdy=1, op_vld=0, out_vld=0, inflight=0, err=0. A spurious res_vld injected after reset, with the FSM in COL_SUM and inflight==0, sets err=1.

Source files
------------

// File: rtl/bfly_addsub_sched.sv
// Radix-2 butterfly scheduler: issues A+B then A-B to one shared complex
// add/sub unit and pairs the two in-order results under a credit limit.
module bfly_addsub_sched #(
   parameter int WIDTH     = 16,
   parameter int MAX_PAIRS = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_a_real,
   input  logic [WIDTH-1:0] in_a_img,
   input  logic [WIDTH-1:0] in_b_real,
   input  logic [WIDTH-1:0] in_b_img,
   output logic             op_vld,
   input  logic             op_rdy,
   output logic             op_is_sub,
   output logic [WIDTH-1:0] op_a_real,
   output logic [WIDTH-1:0] op_a_img,
   output logic [WIDTH-1:0] op_b_real,
   output logic [WIDTH-1:0] op_b_img,
   input  logic             res_vld,
   output logic             res_rdy,
   input  logic [WIDTH-1:0] res_real,
   input  logic [WIDTH-1:0] res_img,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_sum_real,
   output logic [WIDTH-1:0] out_sum_img,
   output logic [WIDTH-1:0] out_dif_real,
   output logic [WIDTH-1:0] out_dif_img,
   output logic [CNT_W-1:0] inflight,
   output logic             err
);

   typedef enum logic [1:0] {ISS_IDLE, ISS_ADD, ISS_SUB} iss_e;
   typedef enum logic [1:0] {COL_SUM, COL_DIF, COL_OUT} col_e;

   localparam logic [CNT_W-1:0] MaxC = CNT_W'(MAX_PAIRS);

   iss_e             iss_q, iss_d;
   col_e             col_q, col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
   logic [WIDTH-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
   logic [WIDTH-1:0] s_re_q, s_im_q, d_re_q, d_im_q;
   logic [WIDTH-1:0] s_re_d, s_im_d, d_re_d, d_im_d;
   logic             acc, dlv;

   // in_rdy depends only on state and credits, never on in_vld
   assign in_rdy    = (iss_q == ISS_IDLE) && (cnt_q < MaxC);
   assign acc       = in_vld && in_rdy;
   assign op_vld    = (iss_q != ISS_IDLE);
   assign op_is_sub = (iss_q == ISS_SUB);
   assign op_a_real = a_re_q;
   assign op_a_img  = a_im_q;
   assign op_b_real = b_re_q;
   assign op_b_img  = b_im_q;

   assign res_rdy      = (col_q != COL_OUT);
   assign out_vld      = (col_q == COL_OUT);
   assign dlv          = out_vld && out_rdy;
   assign out_sum_real = s_re_q;
   assign out_sum_img  = s_im_q;
   assign out_dif_real = d_re_q;
   assign out_dif_img  = d_im_q;
   assign inflight     = cnt_q;
   assign err          = err_q;

   always_comb begin
      iss_d  = iss_q;
      a_re_d = a_re_q;
      a_im_d = a_im_q;
      b_re_d = b_re_q;
      b_im_d = b_im_q;
      unique case (iss_q)
         ISS_IDLE: begin
            if (acc) begin
               a_re_d = in_a_real;
               a_im_d = in_a_img;
               b_re_d = in_b_real;
               b_im_d = in_b_img;
               iss_d  = ISS_ADD;
            end
         end
         ISS_ADD: if (op_rdy) iss_d = ISS_SUB;
         ISS_SUB: if (op_rdy) iss_d = ISS_IDLE;
         default: iss_d = ISS_IDLE;
      endcase
   end

   always_comb begin
      col_d  = col_q;
      s_re_d = s_re_q;
      s_im_d = s_im_q;
      d_re_d = d_re_q;
      d_im_d = d_im_q;
      unique case (col_q)
         COL_SUM: begin
            if (res_vld) begin
               s_re_d = res_real;
               s_im_d = res_img;
               col_d  = COL_DIF;
            end
         end
         COL_DIF: begin
            if (res_vld) begin
               d_re_d = res_real;
               d_im_d = res_img;
               col_d  = COL_OUT;
            end
         end
         COL_OUT: if (out_rdy) col_d = COL_SUM;
         default: col_d = COL_SUM;
      endcase
   end

   // credit count saturates at zero; underflow attempts flag err
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if ((col_q == COL_SUM) && res_vld && (cnt_q == '0)) err_d = 1'b1;
      if (acc && !dlv) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dlv && !acc) begin
         if (cnt_q == '0) err_d = 1'b1;
         else             cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_q  <= ISS_IDLE;
         col_q  <= COL_SUM;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         a_re_q <= '0;
         a_im_q <= '0;
         b_re_q <= '0;
         b_im_q <= '0;
         s_re_q <= '0;
         s_im_q <= '0;
         d_re_q <= '0;
         d_im_q <= '0;
      end else begin
         iss_q  <= iss_d;
         col_q  <= col_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         a_re_q <= a_re_d;
         a_im_q <= a_im_d;
         b_re_q <= b_re_d;
         b_im_q <= b_im_d;
         s_re_q <= s_re_d;
         s_im_q <= s_im_d;
         d_re_q <= d_re_d;
         d_im_q <= d_im_d;
      end
   end

endmodule

// File: tb/tb_bfly_addsub_sched.sv
// Scoreboard bench for bfly_addsub_sched with a behavioural half-precision
// add/sub unit (fixed latency) and random operand/backpressure traffic.
module tb_bfly_addsub_sched;

   localparam int W   = 16;
   localparam int MAXP = 4;
   localparam int CW  = 4;
   localparam int LAT = 4;

   logic          clk, rst_n;
   logic          in_vld, in_rdy;
   logic [W-1:0]  in_a_real, in_a_img, in_b_real, in_b_img;
   logic          op_vld, op_rdy, op_is_sub;
   logic [W-1:0]  op_a_real, op_a_img, op_b_real, op_b_img;
   logic          res_vld, res_rdy;
   logic [W-1:0]  res_real, res_img;
   logic          out_vld, out_rdy;
   logic [W-1:0]  out_sum_real, out_sum_img, out_dif_real, out_dif_img;
   logic [CW-1:0] inflight;
   logic          err;

   bfly_addsub_sched #(.WIDTH(W), .MAX_PAIRS(MAXP), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_rdy(in_rdy),
      .in_a_real(in_a_real), .in_a_img(in_a_img),
      .in_b_real(in_b_real), .in_b_img(in_b_img),
      .op_vld(op_vld), .op_rdy(op_rdy), .op_is_sub(op_is_sub),
      .op_a_real(op_a_real), .op_a_img(op_a_img),
      .op_b_real(op_b_real), .op_b_img(op_b_img),
      .res_vld(res_vld), .res_rdy(res_rdy),
      .res_real(res_real), .res_img(res_img),
      .out_vld(out_vld), .out_rdy(out_rdy),
      .out_sum_real(out_sum_real), .out_sum_img(out_sum_img),
      .out_dif_real(out_dif_real), .out_dif_img(out_dif_img),
      .inflight(inflight), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] ar, ai, br, bi;
   } pair_t;

   typedef struct {
      int unsigned  due;
      logic [W-1:0] re, im;
   } res_t;

   pair_t       stim_q[$];
   logic [63:0] exp_q[$];
   res_t        pipe_q[$];
   logic        issue_log[$];

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;
   int del_cnt = 0;
   int op_mode = 1;
   int out_mode = 1;
   bit err_ok = 0;
   bit inj_req = 0;
   logic [63:0] last_out;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic real h2r(input logic [15:0] h);
      real r;
      int  e;
      e = int'(h[14:10]);
      r = real'(h[9:0]) / 1024.0;
      if (e == 0) begin
         for (int i = 0; i < 14; i++) r = r / 2.0;
      end else begin
         r = r + 1.0;
         for (int i = 0; i < e - 15; i++) r = r * 2.0;
         for (int i = 0; i < 15 - e; i++) r = r / 2.0;
      end
      return h[15] ? -r : r;
   endfunction

   function automatic logic [15:0] r2h(input real x);
      logic s;
      int   e;
      int   m;
      real  v;
      if (x == 0.0) return 16'h0000;
      s = (x < 0.0);
      v = s ? -x : x;
      e = 15;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0) begin v = v * 2.0; e--; end
      m = int'($floor((v - 1.0) * 1024.0));
      return {s, 5'(e), 10'(m)};
   endfunction

   function automatic logic [15:0] fadd(input logic [15:0] a, b);
      return r2h(h2r(a) + h2r(b));
   endfunction

   function automatic logic [15:0] fsub(input logic [15:0] a, b);
      return r2h(h2r(a) - h2r(b));
   endfunction

   function automatic logic [63:0] bfly_ref(input pair_t p);
      return {fadd(p.ar, p.br), fadd(p.ai, p.bi),
              fsub(p.ar, p.br), fsub(p.ai, p.bi)};
   endfunction

   // small multiples of 0.25 keep every sum and difference exact
   function automatic logic [15:0] rnd_h();
      real v;
      v = real'($urandom_range(64, 1)) / 4.0;
      if ($urandom_range(1, 0) == 1) v = -v;
      return r2h(v);
   endfunction

   function automatic pair_t rnd_pair();
      pair_t p;
      p.ar = rnd_h();
      p.ai = rnd_h();
      p.br = rnd_h();
      p.bi = rnd_h();
      return p;
   endfunction

   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input pair_t p);
      stim_q.push_back(p);
   endtask

   // source: in_vld/data change just after posedge, accept decided mid-cycle
   always begin
      pair_t p;
      @(negedge clk);
      if (rst_n && in_vld && in_rdy && stim_q.size() > 0) begin
         p = stim_q.pop_front();
         exp_q.push_back(bfly_ref(p));
         acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (stim_q.size() > 0) begin
         in_vld    = 1'b1;
         in_a_real = stim_q[0].ar;
         in_a_img  = stim_q[0].ai;
         in_b_real = stim_q[0].br;
         in_b_img  = stim_q[0].bi;
      end else begin
         in_vld = 1'b0;
      end
   end

   // behavioural complex add/sub unit with fixed latency
   int unsigned cyc = 0;
   logic        exp_sub = 1'b0;
   bit          hold_op = 0;
   bit          inj_now = 0;
   logic [63:0] held_op;
   always begin
      bit   f_op, f_res;
      res_t r;
      @(negedge clk);
      f_op  = rst_n && op_vld && op_rdy;
      f_res = rst_n && res_vld && res_rdy;
      if (rst_n && hold_op && op_vld)
         chk("op_stable", {op_a_real, op_a_img, op_b_real, op_b_img}, held_op);
      hold_op = rst_n && op_vld && !op_rdy;
      held_op = {op_a_real, op_a_img, op_b_real, op_b_img};
      if (f_op) begin
         chk("op_order", 64'(op_is_sub), 64'(exp_sub));
         exp_sub = ~exp_sub;
         issue_log.push_back(op_is_sub);
         r.re  = op_is_sub ? fsub(op_a_real, op_b_real) : fadd(op_a_real, op_b_real);
         r.im  = op_is_sub ? fsub(op_a_img, op_b_img) : fadd(op_a_img, op_b_img);
         r.due = cyc + LAT - 1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         pipe_q.delete();
         exp_sub = 1'b0;
         hold_op = 0;
         inj_now = 0;
      end else begin
         if (f_res) begin
            if (inj_now) inj_now = 0;
            else if (pipe_q.size() > 0) pipe_q.delete(0);
         end
         if (f_op) pipe_q.push_back(r);
         if (inj_req) begin
            inj_now = 1;
            inj_req = 0;
         end
      end
      if (inj_now) begin
         res_vld  = 1'b1;
         res_real = 16'h1234;
         res_img  = 16'h5678;
      end else if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
         res_vld  = 1'b1;
         res_real = pipe_q[0].re;
         res_img  = pipe_q[0].im;
      end else begin
         res_vld = 1'b0;
      end
      case (op_mode)
         0:       op_rdy = 1'b0;
         1:       op_rdy = 1'b1;
         default: op_rdy = ($urandom_range(3, 0) != 0);
      endcase
   end

   // output monitor and downstream sink
   int          res_n = 0;
   bit          lat_chk = 0;
   bit          out_hold = 0;
   logic [63:0] held_out;
   always begin
      logic [63:0] cur, e;
      @(negedge clk);
      if (!rst_n) begin
         res_n    = 0;
         lat_chk  = 0;
         out_hold = 0;
      end else begin
         if (lat_chk) chk("out_latency", 64'(out_vld), 64'd1);
         lat_chk = 0;
         if (res_vld && res_rdy) begin
            res_n++;
            if (res_n % 2 == 0) lat_chk = 1;
         end
         cur = {out_sum_real, out_sum_img, out_dif_real, out_dif_img};
         if (out_hold && out_vld) chk("out_stable", cur, held_out);
         out_hold = out_vld && !out_rdy;
         held_out = cur;
         if (out_vld && out_rdy) begin
            del_cnt++;
            last_out = cur;
            if (exp_q.size() == 0) begin
               chk("out_extra", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_pair", cur, e);
            end
         end
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
         chk("inflight", 64'(inflight), 64'(acc_cnt - del_cnt));
         if (acc_cnt - del_cnt == MAXP) chk("credit_block", 64'(in_rdy), 64'd0);
         if (!err_ok) chk("err_clear", 64'(err), 64'd0);
      end
      case (out_mode)
         0:       out_rdy = 1'b0;
         1:       out_rdy = 1'b1;
         default: out_rdy = ($urandom_range(2, 0) != 0);
      endcase
   end

   task automatic drain(input string nm, input int budget);
      int t;
      t = 0;
      nstep();
      while ((stim_q.size() != 0 || exp_q.size() != 0 || inflight != 0) &&
             t < budget) begin
         nstep();
         t++;
      end
      chk(nm, 64'(exp_q.size() + stim_q.size()), 64'd0);
      chk({nm, "_inflight"}, 64'(inflight), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pair_t p, x;
      int    t, a0;
      rst_n    = 1'b0;
      in_vld   = 1'b0;
      in_a_real = '0; in_a_img = '0; in_b_real = '0; in_b_img = '0;
      op_rdy   = 1'b1;
      res_vld  = 1'b0;
      res_real = '0;
      res_img  = '0;
      out_rdy  = 1'b1;
      nstep();
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_op_vld", 64'(op_vld), 64'd0);
      chk("rst_op_is_sub", 64'(op_is_sub), 64'd0);
      chk("rst_res_rdy", 64'(res_rdy), 64'd1);
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_out_data", {out_sum_real, out_sum_img, out_dif_real, out_dif_img}, 64'd0);
      nstep();
      rst_n = 1'b1;
      nstep();

      // single pair (1+2j) +/- (0.5+0.5j)
      issue_log.delete();
      p.ar = 16'h3C00; p.ai = 16'h4000; p.br = 16'h3800; p.bi = 16'h3800;
      send(p);
      drain("single_drain", 100);
      chk("single_ops", 64'(issue_log.size()), 64'd2);
      if (issue_log.size() == 2)
         chk("single_seq", 64'({issue_log[0], issue_log[1]}), 64'b01);
      chk("single_out", last_out, 64'h3E00_4100_3800_3E00);

      // credit limit
      out_mode = 0;
      a0 = acc_cnt;
      for (int i = 0; i < 12; i++) send(rnd_pair());
      repeat (60) nstep();
      chk("credit_accepts", 64'(acc_cnt - a0), 64'd4);
      chk("credit_in_rdy", 64'(in_rdy), 64'd0);
      chk("credit_inflight", 64'(inflight), 64'd4);
      out_mode = 1;
      @(posedge clk);
      #2;
      out_mode = 0;
      repeat (30) nstep();
      chk("credit_refill", 64'(acc_cnt - a0), 64'd5);
      stim_q.delete();
      out_mode = 1;
      drain("credit_drain", 200);

      // unit backpressure during ADD
      issue_log.delete();
      op_mode = 0;
      x = rnd_pair();
      send(x);
      send(rnd_pair());
      t = 0;
      nstep();
      while (!op_vld && t < 20) begin nstep(); t++; end
      a0 = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         chk("bp_op_vld", 64'(op_vld), 64'd1);
         chk("bp_is_sub", 64'(op_is_sub), 64'd0);
         chk("bp_ops", {op_a_real, op_a_img, op_b_real, op_b_img},
             {x.ar, x.ai, x.br, x.bi});
         nstep();
      end
      chk("bp_no_accept", 64'(acc_cnt - a0), 64'd0);
      op_mode = 1;
      drain("bp_drain", 200);
      chk("bp_ops_n", 64'(issue_log.size()), 64'd4);
      if (issue_log.size() == 4)
         chk("bp_seq", 64'({issue_log[0], issue_log[1], issue_log[2], issue_log[3]}),
             64'b0101);

      // output stall for 10 cycles
      out_mode = 0;
      send(rnd_pair());
      send(rnd_pair());
      t = 0;
      while (!out_vld && t < 50) begin nstep(); t++; end
      for (int i = 0; i < 10; i++) begin
         chk("stall_res_rdy", 64'(res_rdy), 64'd0);
         chk("stall_out_vld", 64'(out_vld), 64'd1);
         nstep();
      end
      chk("stall_res_held", 64'(res_vld), 64'd1);
      out_mode = 1;
      drain("stall_drain", 200);

      // simultaneous accept and deliver at inflight 2
      out_mode = 0;
      send(rnd_pair());
      send(rnd_pair());
      t = 0;
      while (!(inflight == 2 && in_rdy && out_vld) && t < 60) begin
         nstep();
         t++;
      end
      send(rnd_pair());
      out_mode = 1;
      @(posedge clk);
      #2;
      out_mode = 0;
      nstep();
      chk("both_accept", 64'(in_vld && in_rdy), 64'd1);
      chk("both_deliver", 64'(out_vld && out_rdy), 64'd1);
      @(posedge clk);
      #2;
      chk("both_inflight", 64'(inflight), 64'd2);
      out_mode = 1;
      drain("both_drain", 200);

      // random traffic with random backpressure on both sides
      op_mode  = 2;
      out_mode = 2;
      for (int i = 0; i < 40; i++) send(rnd_pair());
      drain("rand_drain", 3000);

      // async reset in the middle of ISS_SUB with two pairs in flight
      op_mode  = 1;
      out_mode = 0;
      send(rnd_pair());
      send(rnd_pair());
      t = 0;
      nstep();
      while (!(inflight == 2 && op_vld && op_is_sub) && t < 60) begin
         nstep();
         t++;
      end
      chk("arst_setup", 64'(inflight), 64'd2);
      rst_n = 1'b0;
      stim_q.delete();
      exp_q.delete();
      acc_cnt = 0;
      del_cnt = 0;
      #1;
      chk("arst_in_rdy", 64'(in_rdy), 64'd1);
      chk("arst_op_vld", 64'(op_vld), 64'd0);
      chk("arst_out_vld", 64'(out_vld), 64'd0);
      chk("arst_inflight", 64'(inflight), 64'd0);
      chk("arst_err", 64'(err), 64'd0);
      repeat (3) nstep();
      rst_n = 1'b1;
      out_mode = 1;
      repeat (2) nstep();
      chk("post_rst_err", 64'(err), 64'd0);
      err_ok  = 1;
      inj_req = 1;
      nstep();
      chk("spur_res_vld", 64'(res_vld && res_rdy), 64'd1);
      nstep();
      chk("spur_err", 64'(err), 64'd1);
      repeat (3) nstep();
      chk("err_sticky", 64'(err), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
